wtg_bpu: RTL
============

Name: wtg_bpu

Overview:
- Next-generation Where-To-Go unit. It keeps the combinational jump/branch/interrupt target resolution in EX and adds three things:
  - a fetch-side direction predictor (bimodal 2-bit counters),
  - a direct-mapped branch target buffer (BTB),
  - an N-channel prioritised interrupt controller with nesting and ERET unwinding.
- It sits between IF (prediction lookup) and EX (resolution, redirect, table update).
- All addresses are word addresses.

Parameters:
- ADDR_BIT, 10, instruction-memory word-address width
- DEPTH, 16, BHT/BTB entries; power of two, at most 2^ADDR_BIT; IDX_BIT = $clog2(DEPTH)
- N_INTS, 3, interrupt channels; higher index has higher priority
- INT_VEC_BASE, 10'h004, vector of channel 0
- INT_VEC_STRIDE, 10'h004, vector spacing; vector(ch) = INT_VEC_BASE + ch*INT_VEC_STRIDE (ADDR_BIT wrap)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- f_pc  in  ADDR_BIT  fetch PC
- f_pred_taken  out  1  predicted taken
- f_pred_target  out  ADDR_BIT  predicted target; equals f_pc+1 when not predicted taken
- ex_valid  in  1  EX slot holds a live instruction
- ex_op  in  WTG_OP_BIT  WTG opcode (J32, J26, BEQ, BNE, BLTZ, JINT, ERET, NOP)
- ex_imm  in  ADDR_BIT  jump address or branch offset
- ex_data_x  in  32  signed operand x
- ex_data_y  in  32  signed operand y
- ex_pc  in  ADDR_BIT  PC of the EX instruction
- ex_pred_taken  in  1  prediction carried down from IF
- ex_pred_target  in  ADDR_BIT  predicted target carried down from IF
- epc  in  32  byte address used by ERET
- int_req  in  N_INTS  level interrupt requests
- redirect  out  1  flush the front end and refetch from redirect_pc
- redirect_pc  out  ADDR_BIT  correct next PC
- jumped  out  1  unconditional J32/J26 executed
- is_branch  out  1  conditional branch executed
- branched  out  1  conditional branch taken
- jinted  out  1  interrupt entry or ERET executed
- int_pending  out  1  an eligible interrupt awaits; control inserts JINT
- int_ch  out  $clog2(N_INTS)  channel accepted this cycle

Behaviour:
- Reset:
  - all BHT counters = 2'b01 (weakly not-taken); all BTB valid bits = 0;
  - pending = 0; in_service = 0.
  - All outputs derive from these registers and from inputs; none are registered.
- Lookup (combinational, same cycle):
  - idx = f_pc[IDX_BIT-1:0]; tag = f_pc[ADDR_BIT-1:IDX_BIT].
  - f_pred_taken = BTB valid and tag match and BHT[idx][1].
- Resolve (combinational; every output is 0 and redirect_pc = ex_pc+1 when ex_valid = 0):
  - J32: target = ex_data_x[ADDR_BIT+1:2].
  - J26: target = ex_imm.
  - BEQ/BNE/BLTZ: target = ex_pc+1+ex_imm; conditions are x==y, x!=y, x<0 (signed).
  - ERET: target = epc[ADDR_BIT+1:2].
  - JINT: target = vector of the highest eligible channel. If no channel is eligible, JINT is a NOP and jinted = 0.
  - actual_next = target if taken, else ex_pc+1.
  - redirect = (actual_next != ex_pred_target) or (taken != ex_pred_taken).
  - Any op wrongly predicted taken (including NOP) therefore redirects to ex_pc+1.
- Update (posedge clk, when ex_valid):
  - BHT: conditional branches only. Saturating +1 if taken, -1 if not; saturates at 00 and 11.
  - BTB: written for a taken conditional branch or J26 (tag, target, valid = 1). Never written for J32, JINT or ERET.
  - Lookup and update to the same index in the same cycle: the lookup sees the old contents; there is no bypass.
- Interrupts:
  - Eligible channel c: pending[c] = 1 and c is above the highest set in_service bit (any channel is eligible when in_service = 0).
  - Accepted JINT: pending[c] is cleared, in_service[c] is set, and int_ch = c.
  - ERET: clears the highest set in_service bit; this is a no-op if in_service = 0.
  - pending_next = (pending & ~ack) | int_req, so a request in the same cycle as its acceptance is kept.
  - ERET and accept cannot happen in the same cycle, because there is one EX op per cycle.
- Reset mid-operation: all state returns to reset values immediately (asynchronous).

Decomposition:
- Shared Core.vh entries: the WTG_OP_* encodings (existing) plus new BHT counter constants WTG_CNT_WNT = 2'b01 and WTG_CNT_ST = 2'b11.
- One sub-module, wtg_int_ctrl: holds pending/in_service, the priority encoder, vector generation, ERET unwind and the int_pending/int_ch outputs.
- The BHT/BTB arrays and the resolve logic stay in wtg_bpu.

Test Plan:
- Cold branch mispredict then correct prediction:
  - After reset, f_pc=0x010 gives f_pred_taken=0.
  - EX BEQ with ex_pc=0x010, imm=0x005, x=y=7, pred=0 gives redirect=1, redirect_pc=0x016, branched=1.
  - The next BEQ taken at 0x010 moves the BHT to 11 (it was 10 after the first update).
  - f_pc=0x010 then gives f_pred_taken=1, f_pred_target=0x016.
- Aliasing: after the first test, f_pc=0x020 (same idx, tag 0x02) gives f_pred_taken=0.
- Saturation: four not-taken BNE at 0x010 take the counter 11→10→01→00 and it stays at 00. A not-taken branch predicted taken gives redirect=1, redirect_pc=0x011.
- J32: data_x=0x0000_0100, pred=0 gives jumped=1, redirect_pc=0x040; the BTB entry stays invalid.
- Interrupt nesting:
  - int_req=3'b001, then JINT: int_ch=0, redirect_pc=0x004.
  - int_req=3'b100, then JINT: redirect_pc=0x00C.
  - ERET with epc=0x80: redirect_pc=0x020, in_service=3'b001.
  - int_req=3'b001 while channel 0 is in service gives int_pending=0.
- Reset asserted mid-stream: pending, in_service and BTB valid clear without a clock edge; f_pred_taken=0.

Source files
------------

// File: rtl/wtg_bpu_pkg.sv
// Shared WTG definitions: opcode encodings and BHT counter constants.
package wtg_bpu_pkg;

  localparam int unsigned WTG_OP_BIT = 3;

  typedef enum logic [WTG_OP_BIT-1:0] {
    WTG_OP_J32  = 3'd0,
    WTG_OP_J26  = 3'd1,
    WTG_OP_BEQ  = 3'd2,
    WTG_OP_BNE  = 3'd3,
    WTG_OP_BLTZ = 3'd4,
    WTG_OP_JINT = 3'd5,
    WTG_OP_ERET = 3'd6,
    WTG_OP_NOP  = 3'd7
  } wtg_op_e;

  // 2-bit bimodal counter: reset value (weakly not-taken) and upper saturation
  localparam logic [1:0] WTG_CNT_WNT = 2'b01;
  localparam logic [1:0] WTG_CNT_ST  = 2'b11;

endpackage

// File: rtl/wtg_int_ctrl.sv
// Prioritised, nesting interrupt controller for the WTG unit.
// Ports: clk/rst; int_req level requests; ack accepts the highest eligible
// channel (JINT), eret unwinds the highest in-service channel;
// int_pending/int_ch/int_vec describe the eligible/accepted channel.
module wtg_int_ctrl #(
  parameter int unsigned         ADDR_BIT       = 10,
  parameter int unsigned         N_INTS         = 3,
  parameter logic [ADDR_BIT-1:0] INT_VEC_BASE   = ADDR_BIT'(4),
  parameter logic [ADDR_BIT-1:0] INT_VEC_STRIDE = ADDR_BIT'(4),
  localparam int unsigned        CH_BIT         = (N_INTS > 1) ? $clog2(N_INTS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_INTS-1:0]   int_req,
  input  logic                ack,
  input  logic                eret,
  output logic                int_pending,
  output logic [CH_BIT-1:0]   int_ch,
  output logic [ADDR_BIT-1:0] int_vec
);

  logic [N_INTS-1:0] pending;
  logic [N_INTS-1:0] in_service;
  logic [N_INTS-1:0] elig;
  logic [N_INTS-1:0] ack_mask;
  logic [N_INTS-1:0] svc_clr;
  logic [CH_BIT-1:0] svc_top;
  logic [CH_BIT-1:0] best_ch;
  logic              svc_any;

  // Highest channel currently in service
  always_comb begin
    svc_any = 1'b0;
    svc_top = '0;
    for (int c = 0; c < N_INTS; c++) begin
      if (in_service[c]) begin
        svc_any = 1'b1;
        svc_top = CH_BIT'(c);
      end
    end
  end

  // Eligible channels must outrank the active nesting level; pick the highest
  always_comb begin
    elig    = '0;
    best_ch = '0;
    for (int c = 0; c < N_INTS; c++) begin
      if (pending[c] && (!svc_any || (CH_BIT'(c) > svc_top))) begin
        elig[c] = 1'b1;
        best_ch = CH_BIT'(c);
      end
    end
  end

  assign ack_mask    = ack ? (N_INTS'(1) << best_ch) : '0;
  assign svc_clr     = (eret && svc_any) ? (N_INTS'(1) << svc_top) : '0;
  assign int_pending = |elig;
  assign int_ch      = ack ? best_ch : '0;
  assign int_vec     = INT_VEC_BASE + ADDR_BIT'(best_ch) * INT_VEC_STRIDE;

  // A request arriving in the cycle of its own acceptance stays pending
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending    <= '0;
      in_service <= '0;
    end else begin
      pending    <= (pending & ~ack_mask) | int_req;
      in_service <= (in_service | ack_mask) & ~svc_clr;
    end
  end

endmodule

// File: rtl/wtg_bpu.sv
// Where-To-Go unit with bimodal direction predictor, direct-mapped BTB and
// nested interrupt entry. IF side: f_pc -> f_pred_taken/f_pred_target.
// EX side: ex_* resolve -> redirect/redirect_pc and status flags, plus
// table update on the clock edge. int_req feeds the interrupt controller.
module wtg_bpu
  import wtg_bpu_pkg::*;
#(
  parameter int unsigned         ADDR_BIT       = 10,
  parameter int unsigned         DEPTH          = 16,
  parameter int unsigned         N_INTS         = 3,
  parameter logic [ADDR_BIT-1:0] INT_VEC_BASE   = ADDR_BIT'(4),
  parameter logic [ADDR_BIT-1:0] INT_VEC_STRIDE = ADDR_BIT'(4),
  localparam int unsigned        CH_BIT         = (N_INTS > 1) ? $clog2(N_INTS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_BIT-1:0]   f_pc,
  output logic                  f_pred_taken,
  output logic [ADDR_BIT-1:0]   f_pred_target,
  input  logic                  ex_valid,
  input  logic [WTG_OP_BIT-1:0] ex_op,
  input  logic [ADDR_BIT-1:0]   ex_imm,
  input  logic [31:0]           ex_data_x,
  input  logic [31:0]           ex_data_y,
  input  logic [ADDR_BIT-1:0]   ex_pc,
  input  logic                  ex_pred_taken,
  input  logic [ADDR_BIT-1:0]   ex_pred_target,
  input  logic [31:0]           epc,
  input  logic [N_INTS-1:0]     int_req,
  output logic                  redirect,
  output logic [ADDR_BIT-1:0]   redirect_pc,
  output logic                  jumped,
  output logic                  is_branch,
  output logic                  branched,
  output logic                  jinted,
  output logic                  int_pending,
  output logic [CH_BIT-1:0]     int_ch
);

  localparam int unsigned IDX_BIT = $clog2(DEPTH);
  localparam int unsigned TAG_BIT = (ADDR_BIT > IDX_BIT) ? ADDR_BIT - IDX_BIT : 1;

  logic [1:0]          bht        [DEPTH];
  logic [DEPTH-1:0]    btb_valid;
  logic [TAG_BIT-1:0]  btb_tag    [DEPTH];
  logic [ADDR_BIT-1:0] btb_target [DEPTH];

  logic [IDX_BIT-1:0]  f_idx, ex_idx;
  logic [TAG_BIT-1:0]  f_tag, ex_tag;
  logic [ADDR_BIT-1:0] pc_inc, target, int_vec;
  logic [1:0]          cnt_next;
  logic                taken, int_ack, eret, btb_wr;

  assign f_idx  = IDX_BIT'(f_pc);
  assign f_tag  = TAG_BIT'(f_pc >> IDX_BIT);
  assign ex_idx = IDX_BIT'(ex_pc);
  assign ex_tag = TAG_BIT'(ex_pc >> IDX_BIT);
  assign pc_inc = ex_pc + ADDR_BIT'(1);

  // Fetch lookup; reads pre-update contents, no bypass from EX
  assign f_pred_taken  = btb_valid[f_idx] && (btb_tag[f_idx] == f_tag) && bht[f_idx][1];
  assign f_pred_target = f_pred_taken ? btb_target[f_idx] : f_pc + ADDR_BIT'(1);

  wtg_int_ctrl #(
    .ADDR_BIT      (ADDR_BIT),
    .N_INTS        (N_INTS),
    .INT_VEC_BASE  (INT_VEC_BASE),
    .INT_VEC_STRIDE(INT_VEC_STRIDE)
  ) u_int_ctrl (
    .clk        (clk),
    .rst        (rst),
    .int_req    (int_req),
    .ack        (int_ack),
    .eret       (eret),
    .int_pending(int_pending),
    .int_ch     (int_ch),
    .int_vec    (int_vec)
  );

  // EX resolution; JINT with nothing eligible degrades to a NOP
  always_comb begin
    taken     = 1'b0;
    target    = pc_inc;
    jumped    = 1'b0;
    is_branch = 1'b0;
    jinted    = 1'b0;
    int_ack   = 1'b0;
    eret      = 1'b0;
    if (ex_valid) begin
      case (ex_op)
        WTG_OP_J32: begin
          taken  = 1'b1;
          target = ex_data_x[ADDR_BIT+1:2];
          jumped = 1'b1;
        end
        WTG_OP_J26: begin
          taken  = 1'b1;
          target = ex_imm;
          jumped = 1'b1;
        end
        WTG_OP_BEQ, WTG_OP_BNE, WTG_OP_BLTZ: begin
          is_branch = 1'b1;
          target    = pc_inc + ex_imm;
          if (ex_op == WTG_OP_BEQ)      taken = (ex_data_x == ex_data_y);
          else if (ex_op == WTG_OP_BNE) taken = (ex_data_x != ex_data_y);
          else                          taken = ex_data_x[31];
        end
        WTG_OP_JINT: begin
          if (int_pending) begin
            taken   = 1'b1;
            target  = int_vec;
            jinted  = 1'b1;
            int_ack = 1'b1;
          end
        end
        WTG_OP_ERET: begin
          taken  = 1'b1;
          target = epc[ADDR_BIT+1:2];
          jinted = 1'b1;
          eret   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign branched    = is_branch && taken;
  assign redirect_pc = taken ? target : pc_inc;
  assign redirect    = ex_valid &&
                       ((redirect_pc != ex_pred_target) || (taken != ex_pred_taken));
  assign btb_wr      = branched || (ex_valid && (ex_op == WTG_OP_J26));

  // Saturating counter step for the resolving branch
  always_comb begin
    cnt_next = bht[ex_idx];
    if (branched) begin
      if (bht[ex_idx] != WTG_CNT_ST) cnt_next = bht[ex_idx] + 2'd1;
    end else begin
      if (bht[ex_idx] != 2'b00) cnt_next = bht[ex_idx] - 2'd1;
    end
  end

  // Counters and valid bits carry reset state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) bht[IDX_BIT'(i)] <= WTG_CNT_WNT;
      btb_valid <= '0;
    end else begin
      if (is_branch) bht[ex_idx] <= cnt_next;
      if (btb_wr)    btb_valid[ex_idx] <= 1'b1;
    end
  end

  // Tag/target payload is qualified by btb_valid, so it needs no reset
  always_ff @(posedge clk) begin
    if (btb_wr) begin
      btb_tag[ex_idx]    <= ex_tag;
      btb_target[ex_idx] <= target;
    end
  end

endmodule
